ft2232h_tx_arbiter: RTL and testbench

Shares the FT2232H synchronous-FIFO TX bus (data_o / wr_o / txe_i, clocked by the chip's 60 MHz CLKOUT) between NUM_SRC byte-stream sources, such as ADC sample packers and the status/reply path. Grants are round-robin and made per burst. Each burst is optionally prefixed with a channel header byte. Bytes go out through a single output holding register, so no byte is lost or duplicated when TXE# deasserts.

---
 rtl/ft2232h_tx_arbiter_if.sv | 33 +++
 rtl/ft2232h_tx_arbiter.sv | 147 ++++++++++++++
 tb/tb_ft2232h_tx_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ft2232h_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : ft2232h_tx_arbiter_if
//  Brief    : Source byte-stream handshake plus FT2232H sync-FIFO TX bus
//             signals shared by the TX arbiter and its environment.
//  Revision : 1.0 - initial release
// ============================================================================
interface ft2232h_tx_arbiter_if #(
    parameter int NUM_SRC = 2
);
    logic [8*NUM_SRC-1:0] src_data_i;
    logic [NUM_SRC-1:0]   src_valid_i;
    logic [NUM_SRC-1:0]   src_last_i;
    logic [NUM_SRC-1:0]   src_ready_o;
    logic                 txe_i;
    logic [7:0]           data_o;
    logic                 wr_o;
    logic [NUM_SRC-1:0]   grant_o;
    logic                 busy_o;

    // Environment side: drives the sources and the FT2232H TXE# pin
    modport master (
        output src_data_i, src_valid_i, src_last_i, txe_i,
        input  src_ready_o, data_o, wr_o, grant_o, busy_o
    );

    // Arbiter side
    modport slave (
        input  src_data_i, src_valid_i, src_last_i, txe_i,
        output src_ready_o, data_o, wr_o, grant_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/ft2232h_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ft2232h_tx_arbiter
//  Brief    : Round-robin, per-burst arbiter sharing the FT2232H sync-FIFO TX
//             bus between NUM_SRC byte sources, with optional channel header
//             byte and a single output holding register.
//  Revision : 1.0 - initial release
// ============================================================================
module ft2232h_tx_arbiter #(
    parameter int         NUM_SRC   = 2,
    parameter int         MAX_BURST = 64,
    parameter int         HDR_EN    = 1,
    parameter logic [3:0] HDR_TAG   = 4'hA
) (
    input  wire logic              clkout_i,
    input  wire logic              rst_n_i,
    ft2232h_tx_arbiter_if.slave    bus
);

    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_PAY  = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_full;
    logic [7:0]           r_data;
    logic [NUM_SRC-1:0]   r_grant;
    logic [IW-1:0]        r_gidx;
    logic [IW-1:0]        r_ptr;
    logic [7:0]           r_cnt;

    logic                 w_found;
    logic [IW-1:0]        w_pick;
    logic [NUM_SRC-1:0]   w_pick_oh;
    logic [IW:0]          w_cand;
    logic                 w_load_ok;
    logic                 w_accept;
    logic [NUM_SRC-1:0]   w_ready;
    logic                 w_xfer;
    logic                 w_end;
    logic                 w_load_hdr;
    logic                 w_load;
    logic [7:0]           w_hdr_byte;
    logic [7:0]           w_pay_byte;
    logic                 w_pay_last;
    logic [IW-1:0]        w_next_ptr;

    // Round-robin pick: scan offsets high-to-low so the smallest offset from
    // the pointer wins, giving "first valid at or after the pointer".
    always_comb begin
        w_found   = 1'b0;
        w_pick    = '0;
        w_cand    = '0;
        w_pick_oh = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            w_cand = {1'b0, r_ptr} + (IW+1)'(i);
            if (w_cand >= (IW+1)'(NUM_SRC)) begin
                w_cand = w_cand - (IW+1)'(NUM_SRC);
            end
            if (bus.src_valid_i[w_cand[IW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_cand[IW-1:0];
            end
        end
        w_pick_oh[w_pick] = 1'b1;
    end

    // The holding register can take a new byte when empty or when the byte it
    // holds leaves this edge; txe_i reaches src_ready_o combinationally so the
    // bus can sustain one byte per clock.
    assign w_load_ok  = ~r_full | ~bus.txe_i;
    assign w_accept   = r_full & ~bus.txe_i;
    assign w_ready    = (r_state == S_PAY) ? (r_grant & bus.src_valid_i & {NUM_SRC{w_load_ok}}) : '0;
    assign w_xfer     = |w_ready;
    assign w_pay_byte = bus.src_data_i[8*r_gidx +: 8];
    assign w_pay_last = bus.src_last_i[r_gidx];
    assign w_end      = w_xfer & (w_pay_last | (r_cnt == 8'(MAX_BURST - 1)));
    assign w_load_hdr = (r_state == S_HDR) & w_load_ok;
    assign w_load     = w_load_hdr | w_xfer;
    assign w_hdr_byte = {HDR_TAG, 4'(r_gidx)};
    assign w_next_ptr = (r_gidx == IW'(NUM_SRC - 1)) ? '0 : r_gidx + 1'b1;

    // Output holding register: a load wins over a drain since both can
    // happen on the same edge when streaming back-to-back.
    always_ff @(posedge clkout_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_full <= 1'b0;
            r_data <= 8'h00;
        end else if (w_load) begin
            r_full <= 1'b1;
            r_data <= w_load_hdr ? w_hdr_byte : w_pay_byte;
        end else if (w_accept) begin
            r_full <= 1'b0;
        end
    end

    // Burst FSM: grant on IDLE, optional header, payload until last or limit.
    always_ff @(posedge clkout_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_gidx  <= '0;
            r_ptr   <= '0;
            r_cnt   <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_pick_oh;
                        r_gidx  <= w_pick;
                        r_state <= (HDR_EN != 0) ? S_HDR : S_PAY;
                    end
                end
                S_HDR: begin
                    if (w_load_ok) begin
                        r_state <= S_PAY;
                    end
                end
                S_PAY: begin
                    if (w_end) begin
                        r_state <= S_IDLE;
                        r_grant <= '0;
                        r_cnt   <= 8'd0;
                        r_ptr   <= w_next_ptr;
                    end else if (w_xfer) begin
                        r_cnt   <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.src_ready_o = w_ready;
    assign bus.data_o      = r_data;
    assign bus.wr_o        = ~r_full;
    assign bus.grant_o     = r_grant;
    assign bus.busy_o      = (r_state != S_IDLE) | r_full;

endmodule
`default_nettype wire

// File: tb/tb_ft2232h_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ft2232h_tx_arbiter
//  Brief    : Directed self-checking bench for ft2232h_tx_arbiter. Three DUTs
//             with different parameter sets share clock and reset; queue-fed
//             sources and an FT2232H FIFO capture model surround each one.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ft2232h_tx_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    // Instance 0: default; 1: MAX_BURST=4; 2: HDR_EN=0, MAX_BURST=255
    ft2232h_tx_arbiter_if #(.NUM_SRC(2)) ifa ();
    ft2232h_tx_arbiter_if #(.NUM_SRC(2)) ifb ();
    ft2232h_tx_arbiter_if #(.NUM_SRC(2)) ifc ();

    ft2232h_tx_arbiter #(.NUM_SRC(2), .MAX_BURST(64), .HDR_EN(1), .HDR_TAG(4'hA)) u_dut_a (
        .clkout_i (clk), .rst_n_i (rst_n), .bus (ifa.slave));
    ft2232h_tx_arbiter #(.NUM_SRC(2), .MAX_BURST(4), .HDR_EN(1), .HDR_TAG(4'hA)) u_dut_b (
        .clkout_i (clk), .rst_n_i (rst_n), .bus (ifb.slave));
    ft2232h_tx_arbiter #(.NUM_SRC(2), .MAX_BURST(255), .HDR_EN(0), .HDR_TAG(4'hA)) u_dut_c (
        .clkout_i (clk), .rst_n_i (rst_n), .bus (ifc.slave));

    logic [15:0] sdata  [3];
    logic [1:0]  svalid [3];
    logic [1:0]  slast  [3];
    logic        txe    [3];

    assign ifa.src_data_i = sdata[0];  assign ifa.src_valid_i = svalid[0];
    assign ifa.src_last_i = slast[0];  assign ifa.txe_i       = txe[0];
    assign ifb.src_data_i = sdata[1];  assign ifb.src_valid_i = svalid[1];
    assign ifb.src_last_i = slast[1];  assign ifb.txe_i       = txe[1];
    assign ifc.src_data_i = sdata[2];  assign ifc.src_valid_i = svalid[2];
    assign ifc.src_last_i = slast[2];  assign ifc.txe_i       = txe[2];

    wire [1:0] rdy  [3];
    wire       wr   [3];
    wire [7:0] dout [3];
    wire [1:0] gnt  [3];
    wire       bsy  [3];

    assign rdy[0] = ifa.src_ready_o; assign wr[0] = ifa.wr_o; assign dout[0] = ifa.data_o;
    assign gnt[0] = ifa.grant_o;     assign bsy[0] = ifa.busy_o;
    assign rdy[1] = ifb.src_ready_o; assign wr[1] = ifb.wr_o; assign dout[1] = ifb.data_o;
    assign gnt[1] = ifb.grant_o;     assign bsy[1] = ifb.busy_o;
    assign rdy[2] = ifc.src_ready_o; assign wr[2] = ifc.wr_o; assign dout[2] = ifc.data_o;
    assign gnt[2] = ifc.grant_o;     assign bsy[2] = ifc.busy_o;

    // Source queues ({last, byte}) indexed dut*2+src, and captured FIFO bytes
    logic [8:0] srcq [6][$];
    logic [7:0] cap  [3][$];
    logic [7:0] exp_q [$];

    // Source and FIFO model: sample handshakes just before each rising edge,
    // then retire taken bytes and present the next queue heads after it.
    initial begin : driver
        logic [1:0] pre_rdy [3];
        logic       pre_acc [3];
        logic [7:0] pre_dat [3];
        for (int d = 0; d < 3; d++) begin
            sdata[d] = 16'h0; svalid[d] = 2'b0; slast[d] = 2'b0;
        end
        forever begin
            @(negedge clk); #4;
            for (int d = 0; d < 3; d++) begin
                pre_rdy[d] = rdy[d];
                pre_acc[d] = rst_n && !wr[d] && !txe[d];
                pre_dat[d] = dout[d];
            end
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                if (pre_acc[d]) cap[d].push_back(pre_dat[d]);
                for (int k = 0; k < 2; k++) begin
                    if (pre_rdy[d][k] && srcq[d*2+k].size() > 0) void'(srcq[d*2+k].pop_front());
                    if (srcq[d*2+k].size() > 0) begin
                        svalid[d][k]        = 1'b1;
                        slast[d][k]         = srcq[d*2+k][0][8];
                        sdata[d][8*k +: 8]  = srcq[d*2+k][0][7:0];
                    end else begin
                        svalid[d][k] = 1'b0;
                        slast[d][k]  = 1'b0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int d, input int k, input logic [7:0] b, input logic last);
        srcq[d*2+k].push_back({last, b});
    endtask

    task automatic check_stream(input int d, input string tag);
        check({tag, " len"}, cap[d].size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < cap[d].size()) check($sformatf("%s[%0d]", tag, i), cap[d][i], exp_q[i]);
        end
        cap[d].delete();
        exp_q.delete();
    endtask

    task automatic wait_cap(input int d, input int n, input int budget, input string tag);
        int c = 0;
        while (cap[d].size() < n && c < budget) begin
            tick();
            c++;
        end
        check({tag, " wait"}, 32'(cap[d].size() >= n), 32'd1);
    endtask

    initial begin : stimulus
        int lowcnt, run, maxrun;
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) txe[d] = 1'b0;
        #2;
        check("rst data_o",  dout[0], 8'h00);
        check("rst wr_o",    wr[0],   1'b1);
        check("rst grant_o", gnt[0],  2'b00);
        check("rst busy_o",  bsy[0],  1'b0);
        check("rst ready",   rdy[0],  2'b00);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Single 3-byte packet: header plus payload in 4 back-to-back writes
        push(0, 0, 8'h11, 1'b0); push(0, 0, 8'h22, 1'b0); push(0, 0, 8'h33, 1'b1);
        lowcnt = 0; run = 0; maxrun = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 1) begin
                check("t1 grant_o", gnt[0], 2'b01);
                check("t1 busy_o",  bsy[0], 1'b1);
            end
            if (!wr[0]) begin
                lowcnt++; run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
        end
        check("t1 wr low cycles", lowcnt, 4);
        check("t1 wr low run",    maxrun, 4);
        check("t1 grant idle",    gnt[0], 2'b00);
        exp_q = '{8'hA0, 8'h11, 8'h22, 8'h33};
        check_stream(0, "t1");

        // One byte on src1 returns the pointer to src0
        push(0, 1, 8'h7E, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        exp_q = '{8'hA1, 8'h7E};
        check_stream(0, "t1b");

        // Two simultaneous requesters, twice
        push(0, 0, 8'h01, 1'b0); push(0, 0, 8'h02, 1'b1);
        push(0, 1, 8'h81, 1'b0); push(0, 1, 8'h82, 1'b1);
        for (int i = 0; i < 20; i++) tick();
        exp_q = '{8'hA0, 8'h01, 8'h02, 8'hA1, 8'h81, 8'h82};
        check_stream(0, "t2a");
        push(0, 0, 8'h03, 1'b1);
        push(0, 1, 8'h83, 1'b1);
        for (int i = 0; i < 16; i++) tick();
        exp_q = '{8'hA0, 8'h03, 8'hA1, 8'h83};
        check_stream(0, "t2b");

        // TXE# stall after the 2nd payload byte of a 5-byte packet
        for (int i = 0; i < 5; i++) push(0, 0, 8'h51 + 8'(i), i == 4);
        wait_cap(0, 3, 20, "t3");
        txe[0] = 1'b1;
        #1;
        check("t3 stall ready", rdy[0], 2'b00);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t3 hold data %0d", i), dout[0], 8'h53);
            check($sformatf("t3 hold wr %0d", i),   wr[0],   1'b0);
            check($sformatf("t3 hold rdy %0d", i),  rdy[0],  2'b00);
        end
        txe[0] = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        exp_q = '{8'hA0, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
        check_stream(0, "t3");

        // MAX_BURST=4 forced rotation, src0 left mid-packet
        for (int i = 0; i < 6; i++) push(1, 0, 8'h60 + 8'(i), 1'b0);
        push(1, 1, 8'h70, 1'b1);
        for (int i = 0; i < 30; i++) tick();
        exp_q = '{8'hA0, 8'h60, 8'h61, 8'h62, 8'h63, 8'hA1, 8'h70, 8'hA0, 8'h64, 8'h65};
        check_stream(1, "t4");
        check("t4 grant held", gnt[1], 2'b01);
        check("t4 busy held",  bsy[1], 1'b1);
        check("t4 no ready",   rdy[1], 2'b00);

        // HDR_EN=0, 256-byte packet split by the 255-byte limit
        for (int i = 0; i < 256; i++) push(2, 1, 8'(i), i == 255);
        wait_cap(2, 256, 400, "t6");
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 256; i++) exp_q.push_back(8'(i));
        check_stream(2, "t6");
        check("t6 grant idle", gnt[2], 2'b00);

        // Asynchronous reset mid-payload
        for (int i = 0; i < 8; i++) push(0, 0, 8'h91 + 8'(i), i == 7);
        wait_cap(0, 3, 20, "t5");
        #1;
        rst_n = 1'b0;
        #1;
        check("t5 wr_o",    wr[0],   1'b1);
        check("t5 grant_o", gnt[0],  2'b00);
        check("t5 data_o",  dout[0], 8'h00);
        check("t5 busy_o",  bsy[0],  1'b0);
        srcq[0].delete(); srcq[1].delete();
        cap[0].delete();
        tick(); tick();
        rst_n = 1'b1;
        tick();
        push(0, 0, 8'hB1, 1'b1);
        push(0, 1, 8'hC1, 1'b1);
        for (int i = 0; i < 20; i++) tick();
        exp_q = '{8'hA0, 8'hB1, 8'hA1, 8'hC1};
        check_stream(0, "t5");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
